// File: rtl/matrix_num_loader.sv
// matrix_num_loader: reads a matrix header [rows, cols] and rows*cols
// row-major elements from a synchronous number RAM, validates the
// header against the available word count, and streams each element
// with its (row, col) coordinates over a valid/ready beat interface.
//
// Beat handshake: elem_valid is raised only in SEND and, once raised,
// elem_data/elem_row/elem_col stay constant until the cycle in which
// elem_ready is also high; the beat transfers on that rising edge.
// elem_valid never depends combinationally on elem_ready.
module matrix_num_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int MAX_DIM    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [10:0]           num_count,
    output logic [ADDR_WIDTH-1:0] src_rd_addr,
    input  logic [DATA_WIDTH-1:0] src_rd_data,
    output logic [7:0]            mat_rows,
    output logic [7:0]            mat_cols,
    output logic                  elem_valid,
    input  logic                  elem_ready,
    output logic [DATA_WIDTH-1:0] elem_data,
    output logic [7:0]            elem_row,
    output logic [7:0]            elem_col,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [3:0]            dbg_state
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        RD_ROWS  = 4'd1,
        RD_COLS  = 4'd2,
        CAP_COLS = 4'd3,
        CHECK    = 4'd4,
        REQ_ELEM = 4'd5,
        CAP_ELEM = 4'd6,
        SEND     = 4'd7,
        DONE     = 4'd8,
        FAIL     = 4'd9
    } state_e;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_SHORT = 2'd1;
    localparam logic [1:0] ERR_DIM   = 2'd2;
    localparam logic [1:0] ERR_COUNT = 2'd3;

    state_e                state_q, state_d;
    logic [10:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rows_word_q, rows_word_d;
    logic [DATA_WIDTH-1:0] cols_word_q, cols_word_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [15:0]           idx_q, idx_d;
    logic [15:0]           total_q, total_d;
    logic [7:0]            row_q, row_d;
    logic [7:0]            col_q, col_d;
    logic [1:0]            err_q, err_d;

    // Header decode: the full words are kept so CHECK can reject words
    // whose upper bits are set (which also covers negative values).
    logic [7:0]  rows_lo, cols_lo;
    logic        rows_bad, cols_bad;
    logic [15:0] dim_prod;
    logic [15:0] elem_need;

    assign rows_lo   = rows_word_q[7:0];
    assign cols_lo   = cols_word_q[7:0];
    assign rows_bad  = (|rows_word_q[DATA_WIDTH-1:8]) || (rows_lo == 8'd0) || (rows_lo > 8'(MAX_DIM));
    assign cols_bad  = (|cols_word_q[DATA_WIDTH-1:8]) || (cols_lo == 8'd0) || (cols_lo > 8'(MAX_DIM));
    assign dim_prod  = {8'd0, rows_lo} * {8'd0, cols_lo};
    assign elem_need = {5'd0, cnt_q} - 16'd2;

    assign mat_rows  = rows_lo;
    assign mat_cols  = cols_lo;
    assign elem_data = data_q;
    assign elem_row  = row_q;
    assign elem_col  = col_q;
    assign err_code  = err_q;
    assign done      = (state_q == DONE);
    assign error     = (state_q == FAIL);
    assign busy      = (state_q != IDLE) && (state_q != DONE) && (state_q != FAIL);
    assign dbg_state = state_q;

    // State and datapath registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rows_word_q <= '0;
            cols_word_q <= '0;
            data_q      <= '0;
            idx_q       <= '0;
            total_q     <= '0;
            row_q       <= '0;
            col_q       <= '0;
            err_q       <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rows_word_q <= rows_word_d;
            cols_word_q <= cols_word_d;
            data_q      <= data_d;
            idx_q       <= idx_d;
            total_q     <= total_d;
            row_q       <= row_d;
            col_q       <= col_d;
            err_q       <= err_d;
        end
    end

    // Next-state, read address and beat-valid decode; abort overrides all.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rows_word_d = rows_word_q;
        cols_word_d = cols_word_q;
        data_d      = data_q;
        idx_d       = idx_q;
        total_d     = total_q;
        row_d       = row_q;
        col_d       = col_q;
        err_d       = err_q;
        src_rd_addr = '0;
        elem_valid  = 1'b0;

        case (state_q)
            IDLE, DONE, FAIL: begin
                if (start) begin
                    cnt_d       = num_count;
                    rows_word_d = '0;
                    cols_word_d = '0;
                    err_d       = ERR_NONE;
                    if (num_count < 11'd2) begin
                        // Not even a header available: reject without reading.
                        state_d = FAIL;
                        err_d   = ERR_SHORT;
                    end else begin
                        state_d = RD_ROWS;
                    end
                end
            end
            RD_ROWS: begin
                src_rd_addr = '0;
                state_d     = RD_COLS;
            end
            RD_COLS: begin
                src_rd_addr = ADDR_WIDTH'(1);
                rows_word_d = src_rd_data;
                state_d     = CAP_COLS;
            end
            CAP_COLS: begin
                cols_word_d = src_rd_data;
                state_d     = CHECK;
            end
            CHECK: begin
                if (rows_bad || cols_bad) begin
                    state_d = FAIL;
                    err_d   = ERR_DIM;
                end else if (dim_prod != elem_need) begin
                    state_d = FAIL;
                    err_d   = ERR_COUNT;
                end else begin
                    idx_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                    total_d = dim_prod;
                    state_d = REQ_ELEM;
                end
            end
            REQ_ELEM: begin
                src_rd_addr = ADDR_WIDTH'(idx_q + 16'd2);
                state_d     = CAP_ELEM;
            end
            CAP_ELEM: begin
                data_d  = src_rd_data;
                state_d = SEND;
            end
            SEND: begin
                elem_valid = 1'b1;
                if (elem_ready) begin
                    if (idx_q == total_q - 16'd1) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 16'd1;
                        if (col_q == cols_lo - 8'd1) begin
                            col_d = '0;
                            row_d = row_q + 8'd1;
                        end else begin
                            col_d = col_q + 8'd1;
                        end
                        state_d = REQ_ELEM;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d = IDLE;
            err_d   = ERR_NONE;
            idx_d   = idx_q;
            row_d   = row_q;
            col_d   = col_q;
        end
    end

endmodule

// File: tb/tb_matrix_num_loader.sv
// Directed bench for matrix_num_loader: a one-cycle-latency RAM model,
// hand-computed expected beats, and immediate assertions at each check.
module tb_matrix_num_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [10:0] num_count;
    logic [10:0] src_rd_addr;
    logic [31:0] src_rd_data;
    logic [7:0]  mat_rows, mat_cols;
    logic        elem_valid;
    logic        elem_ready;
    logic [31:0] elem_data;
    logic [7:0]  elem_row, elem_col;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [3:0]  dbg_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int valid_cycles  = 0;
    int addr_nz_cycles = 0;

    logic [31:0] mem [0:63];

    // Expected beats for the [2,2,10,-3,7,0] matrix.
    int          exp_row  [4] = '{0, 0, 1, 1};
    int          exp_col  [4] = '{0, 1, 0, 1};
    logic [31:0] exp_data [4] = '{32'd10, 32'hFFFF_FFFD, 32'd7, 32'd0};

    matrix_num_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .num_count  (num_count),
        .src_rd_addr(src_rd_addr),
        .src_rd_data(src_rd_data),
        .mat_rows   (mat_rows),
        .mat_cols   (mat_cols),
        .elem_valid (elem_valid),
        .elem_ready (elem_ready),
        .elem_data  (elem_data),
        .elem_row   (elem_row),
        .elem_col   (elem_col),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    // RAM model with one cycle of read latency, plus activity counters.
    always @(posedge clk) begin
        src_rd_data <= mem[src_rd_addr[5:0]];
        cyc <= cyc + 1;
        if (elem_valid) valid_cycles <= valid_cycles + 1;
        if (src_rd_addr != 11'd0) addr_nz_cycles <= addr_nz_cycles + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ram(input logic [31:0] w0, w1, w2, w3, w4, w5);
        mem[0] = w0; mem[1] = w1; mem[2] = w2;
        mem[3] = w3; mem[4] = w4; mem[5] = w5;
    endtask

    task automatic start_load(input int n);
        num_count = 11'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!elem_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, {31'd0, elem_valid}, 32'd1);
    endtask

    task automatic expect_beat(input string tag, input int r, input int c, input logic [31:0] d);
        wait_valid(tag);
        check({tag, "_row"}, {24'd0, elem_row}, 32'(r));
        check({tag, "_col"}, {24'd0, elem_col}, 32'(c));
        check({tag, "_data"}, elem_data, d);
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!(done || error) && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_end"}, {31'd0, done | error}, 32'd1);
    endtask

    task automatic check_done(input string tag);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_rows"}, {24'd0, mat_rows}, 32'd2);
        check({tag, "_cols"}, {24'd0, mat_cols}, 32'd2);
        check({tag, "_errcode"}, {30'd0, err_code}, 32'd0);
        check({tag, "_addr"}, {21'd0, src_rd_addr}, 32'd0);
    endtask

    // Full 2x2 stream with elem_ready held high: beats must be 3 cycles apart.
    task automatic run_stream(input string tag);
        int prev = 0;
        elem_ready = 1'b1;
        start_load(6);
        check({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            expect_beat($sformatf("%s_b%0d", tag, k), exp_row[k], exp_col[k], exp_data[k]);
            if (k > 0) check($sformatf("%s_gap%0d", tag, k), 32'(cyc - prev), 32'd3);
            prev = cyc;
            tick();
        end
        check_done(tag);
    endtask

    task automatic check_err(input string tag, input int code);
        check({tag, "_error"}, {31'd0, error}, 32'd1);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_code"}, {30'd0, err_code}, 32'(code));
    endtask

    initial begin
        int vc;
        int an;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; elem_ready = 1'b0; num_count = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        tick(); tick();

        // Reset state, held through deassertion until start.
        check("rst_state", {28'd0, dbg_state}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, elem_valid}, 32'd0);
        check("rst_done_err", {30'd0, done, error}, 32'd0);
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("idle_state", {28'd0, dbg_state}, 32'd0);
        check("idle_addr", {21'd0, src_rd_addr}, 32'd0);

        // Basic 2x2 stream.
        set_ram(32'd2, 32'd2, 32'd10, 32'hFFFF_FFFD, 32'd7, 32'd0);
        run_stream("basic");
        tick(); tick();
        check("done_hold", {31'd0, done}, 32'd1);

        // Backpressure on beat 1 for 5 cycles.
        elem_ready = 1'b1;
        start_load(6);
        expect_beat("bp_b0", 0, 0, 32'd10);
        tick();
        elem_ready = 1'b0;
        expect_beat("bp_b1", 0, 1, 32'hFFFF_FFFD);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_hold_valid%0d", i), {31'd0, elem_valid}, 32'd1);
            check($sformatf("bp_hold_data%0d", i), elem_data, 32'hFFFF_FFFD);
        end
        elem_ready = 1'b1;
        tick();
        expect_beat("bp_b2", 1, 0, 32'd7);
        tick();
        expect_beat("bp_b3", 1, 1, 32'd0);
        tick();
        check_done("bp");

        // Dimension errors.
        set_ram(32'd0, 32'd3, 32'd1, 32'd2, 32'd3, 32'd4);
        vc = valid_cycles;
        start_load(5);
        wait_end("dim0");
        check_err("dim0", 2);
        check("dim0_novalid", 32'(valid_cycles - vc), 32'd0);
        check("dim0_cols", {24'd0, mat_cols}, 32'd3);

        set_ram(32'd17, 32'd1, 32'd1, 32'd2, 32'd3, 32'd4);
        start_load(19);
        wait_end("dim17");
        check_err("dim17", 2);
        check("dim17_rows", {24'd0, mat_rows}, 32'd17);

        set_ram(32'h0000_0102, 32'd2, 32'd1, 32'd2, 32'd3, 32'd4);
        start_load(6);
        wait_end("dimhi");
        check_err("dimhi", 2);

        set_ram(32'd2, 32'hFFFF_FF02, 32'd1, 32'd2, 32'd3, 32'd4);
        start_load(6);
        wait_end("dimneg");
        check_err("dimneg", 2);

        // MAX_DIM itself is legal: first beat appears, then abort.
        set_ram(32'd16, 32'd1, 32'd10, 32'd11, 32'd12, 32'd13);
        elem_ready = 1'b0;
        start_load(18);
        expect_beat("max16_b0", 0, 0, 32'd10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("max16_abort_state", {28'd0, dbg_state}, 32'd0);

        // Count errors.
        set_ram(32'd2, 32'd2, 32'd1, 32'd2, 32'd3, 32'd0);
        start_load(5);
        wait_end("cnt5");
        check_err("cnt5", 3);

        an = addr_nz_cycles;
        start_load(1);
        check_err("short1", 1);
        check("short1_addr", {21'd0, src_rd_addr}, 32'd0);
        tick(); tick();
        check("short1_noread", 32'(addr_nz_cycles - an), 32'd0);

        // Reset during SEND of beat 1, then a clean rerun.
        set_ram(32'd2, 32'd2, 32'd10, 32'hFFFF_FFFD, 32'd7, 32'd0);
        elem_ready = 1'b0;
        start_load(6);
        expect_beat("rs_b0", 0, 0, 32'd10);
        elem_ready = 1'b1;
        tick();
        elem_ready = 1'b0;
        expect_beat("rs_b1", 0, 1, 32'hFFFF_FFFD);
        rst_n = 1'b0;
        #1;
        check("rs_valid", {31'd0, elem_valid}, 32'd0);
        check("rs_busy", {31'd0, busy}, 32'd0);
        check("rs_data", elem_data, 32'd0);
        check("rs_rowcol", {16'd0, elem_row, elem_col}, 32'd0);
        check("rs_dims", {16'd0, mat_rows, mat_cols}, 32'd0);
        check("rs_flags", {28'd0, done, error, err_code}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rs_idle", {28'd0, dbg_state}, 32'd0);
        run_stream("rerun");

        // Abort beats a same-cycle handshake.
        elem_ready = 1'b0;
        start_load(6);
        expect_beat("ab_b0", 0, 0, 32'd10);
        elem_ready = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_state", {28'd0, dbg_state}, 32'd0);
        check("ab_busy", {31'd0, busy}, 32'd0);
        check("ab_valid", {31'd0, elem_valid}, 32'd0);
        check("ab_flags", {30'd0, done, error}, 32'd0);
        check("ab_col", {24'd0, elem_col}, 32'd0);

        // Abort has priority over start.
        abort = 1'b1;
        start_load(6);
        abort = 1'b0;
        check("abst_state", {28'd0, dbg_state}, 32'd0);

        // start while busy is ignored.
        elem_ready = 1'b1;
        start_load(6);
        expect_beat("ign_b0", 0, 0, 32'd10);
        num_count = 11'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_beat("ign_b1", 0, 1, 32'hFFFF_FFFD);
        tick();
        expect_beat("ign_b2", 1, 0, 32'd7);
        tick();
        expect_beat("ign_b3", 1, 1, 32'd0);
        tick();
        check_done("ign");

        // Accepted start from DONE clears done before the new error.
        start_load(1);
        check_err("redo", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
